audio_filter_sequencer: RTL and testbench
=========================================

Name: audio_filter_sequencer

Overview:
- Frame-level controller between the audio codec's sample handshake and one shared moving-average filter engine.
- Reads a stereo frame from the codec and time-multiplexes the left then right sample through the filter, one enable pulse each.
- Returns the filtered pair to the codec.
- Provides per-frame bypass, a write-stall timeout with drop counting, and a completed-frame counter.

Parameters:
WIDTH, 24, sample width in bits (signed two's complement).
TIMEOUT, 4096, max cycles spent waiting for write_ready before a frame is dropped (≥2).
CNT_W, 16, width of the frame and drop counters.

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
read_ready  in  1  codec has a stereo input frame available.
readdata_left  in  WIDTH  codec left input sample, valid while read_ready=1.
readdata_right  in  WIDTH  codec right input sample, valid while read_ready=1.
read  out  1  one-cycle pop of the codec input frame.
write_ready  in  1  codec can accept an output frame.
writedata_left  out  WIDTH  filtered/bypassed left sample (registered).
writedata_right  out  WIDTH  filtered/bypassed right sample (registered).
write  out  1  one-cycle push of the output frame.
bypass  in  1  1 = pass samples through unfiltered; sampled on the read cycle.
filt_en  out  1  advance the filter engine by one sample this cycle.
filt_sel  out  1  filter channel bank (0 = left, 1 = right).
filt_in  out  WIDTH  sample presented to the filter engine.
filt_out  in  WIDTH  filter result for filt_in; combinational, valid in the same cycle as filt_en.
frames_done  out  CNT_W  frames written to the codec; wraps.
drop_count  out  CNT_W  frames dropped on timeout; saturates at all-ones.
busy  out  1  state != IDLE.

Behaviour:
- Reset: all outputs are 0, state is IDLE, latched samples are 0, timeout counter is 0. Reset mid-frame abandons the frame without asserting read, write or filt_en, and does not increment drop_count.
- FSM states: IDLE, FILT_L, FILT_R, WAIT_WR.
- IDLE:
  - read = read_ready (combinational).
  - When read_ready=1: latch readdata_left/right into in_l/in_r, latch bypass into byp, go to FILT_L.
  - Otherwise stay in IDLE.
- FILT_L:
  - filt_sel=0, filt_in=in_l, filt_en=~byp.
  - Register writedata_left = byp ? in_l : filt_out.
  - Go to FILT_R.
- FILT_R:
  - filt_sel=1, filt_in=in_r, filt_en=~byp.
  - Register writedata_right = byp ? in_r : filt_out.
  - Clear the timeout counter and go to WAIT_WR.
- WAIT_WR:
  - write = write_ready (combinational).
  - On write: frames_done++ and go to IDLE.
  - Otherwise, if the timeout counter = TIMEOUT-1: drop_count++ (saturating), go to IDLE, leave writedata unchanged.
  - Otherwise increment the timeout counter.
  - If write_ready and the timeout condition coincide, the write wins and nothing is dropped.
- Outside its asserting states, read, write and filt_en are 0. filt_in and filt_sel are 0 outside FILT_L/FILT_R.
- Latency: read in cycle t, filt_en at t+1 (L) and t+2 (R), earliest write at t+3. The frame period is ≥4 cycles, with no back-to-back read from WAIT_WR. A new read cannot occur before the write or drop of the current frame; codec input is back-pressured, not lost.
- Bypass leaves the filter state untouched (filt_en stays 0) and keeps latency identical. Toggling bypass mid-frame has no effect until the next read.
- filt_out is used unmodified, with no width change. The sequencer performs no arithmetic on samples.

Test Plan:
- Reset, then read_ready=1 with L=100, R=-200, bypass=0, filter model returning input/8, write_ready=1 → read at t, filt_en at t+1 (sel 0, in 100) and t+2 (sel 1, in -200), write at t+3 with writedata 12/-25, frames_done=1.
- bypass=1, L=0x7FFFFF, R=0x800000 → filt_en never asserted; write at t+3 with writedata 0x7FFFFF/0x800000.
- TIMEOUT=8, write_ready held 0 → no write; drop_count=1 after 8 cycles in WAIT_WR; busy falls; the next read_ready is accepted normally.
- TIMEOUT=8, write_ready rises exactly on the 8th WAIT_WR cycle → write asserted, frames_done++, drop_count unchanged.
- read_ready held 1 continuously with write_ready=1 → read pulses exactly every 4 cycles; 10 frames give frames_done=10.
- Assert reset during FILT_R → next cycle is IDLE, all outputs 0, no write, counters 0.

Source files
------------

// File: rtl/audio_filter_sequencer.sv
// Frame sequencer between a stereo codec handshake and one shared moving-average filter.
// Each frame: pop from codec, run left then right through the filter, push result back.
module audio_filter_sequencer #(
   parameter int WIDTH   = 24,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             read_ready,
   input  logic [WIDTH-1:0] readdata_left,
   input  logic [WIDTH-1:0] readdata_right,
   output logic             read,
   input  logic             write_ready,
   output logic [WIDTH-1:0] writedata_left,
   output logic [WIDTH-1:0] writedata_right,
   output logic             write,
   input  logic             bypass,
   output logic             filt_en,
   output logic             filt_sel,
   output logic [WIDTH-1:0] filt_in,
   input  logic [WIDTH-1:0] filt_out,
   output logic [CNT_W-1:0] frames_done,
   output logic [CNT_W-1:0] drop_count,
   output logic             busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FILT_L  = 2'd1;
   localparam logic [1:0] FILT_R  = 2'd2;
   localparam logic [1:0] WAIT_WR = 2'd3;

   localparam int              TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] in_l_q, in_l_d;
   logic [WIDTH-1:0] in_r_q, in_r_d;
   logic             byp_q, byp_d;
   logic [WIDTH-1:0] wr_l_q, wr_l_d;
   logic [WIDTH-1:0] wr_r_q, wr_r_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [CNT_W-1:0] frames_q, frames_d;
   logic [CNT_W-1:0] drops_q, drops_d;

   always_comb begin
      state_d  = state_q;
      in_l_d   = in_l_q;
      in_r_d   = in_r_q;
      byp_d    = byp_q;
      wr_l_d   = wr_l_q;
      wr_r_d   = wr_r_q;
      tmo_d    = tmo_q;
      frames_d = frames_q;
      drops_d  = drops_q;
      read     = 1'b0;
      write    = 1'b0;
      filt_en  = 1'b0;
      filt_sel = 1'b0;
      filt_in  = '0;

      case (state_q)
         IDLE: begin
            if (read_ready) begin
               read    = 1'b1;
               in_l_d  = readdata_left;
               in_r_d  = readdata_right;
               byp_d   = bypass;
               state_d = FILT_L;
            end
         end
         FILT_L: begin
            filt_in = in_l_q;
            filt_en = ~byp_q;
            wr_l_d  = byp_q ? in_l_q : filt_out;
            state_d = FILT_R;
         end
         FILT_R: begin
            filt_sel = 1'b1;
            filt_in  = in_r_q;
            filt_en  = ~byp_q;
            wr_r_d   = byp_q ? in_r_q : filt_out;
            tmo_d    = '0;
            state_d  = WAIT_WR;
         end
         default: begin
            // A write in the final timeout cycle still wins over the drop.
            if (write_ready) begin
               write    = 1'b1;
               frames_d = frames_q + CNT_W'(1);
               state_d  = IDLE;
            end else if (tmo_q == TMO_LAST) begin
               if (drops_q != '1) drops_d = drops_q + CNT_W'(1);
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
      endcase

      // Handshake strobes are suppressed while reset is held so a frame is abandoned cleanly.
      if (reset) begin
         read     = 1'b0;
         write    = 1'b0;
         filt_en  = 1'b0;
         filt_sel = 1'b0;
         filt_in  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         in_l_q   <= '0;
         in_r_q   <= '0;
         byp_q    <= 1'b0;
         wr_l_q   <= '0;
         wr_r_q   <= '0;
         tmo_q    <= '0;
         frames_q <= '0;
         drops_q  <= '0;
      end else begin
         state_q  <= state_d;
         in_l_q   <= in_l_d;
         in_r_q   <= in_r_d;
         byp_q    <= byp_d;
         wr_l_q   <= wr_l_d;
         wr_r_q   <= wr_r_d;
         tmo_q    <= tmo_d;
         frames_q <= frames_d;
         drops_q  <= drops_d;
      end
   end

   assign writedata_left  = wr_l_q;
   assign writedata_right = wr_r_q;
   assign frames_done     = frames_q;
   assign drop_count      = drops_q;
   assign busy            = (state_q != IDLE) && !reset;

endmodule

// File: tb/tb_audio_filter_sequencer.sv
// Scoreboard bench: a cycle-window model of each frame predicts strobes, data and counters.
module tb_audio_filter_sequencer;
   localparam int W   = 24;
   localparam int TMO = 8;
   localparam int CW  = 16;

   logic          clk;
   logic          reset;
   logic          read_ready;
   logic [W-1:0]  readdata_left;
   logic [W-1:0]  readdata_right;
   logic          read;
   logic          write_ready;
   logic [W-1:0]  writedata_left;
   logic [W-1:0]  writedata_right;
   logic          write;
   logic          bypass;
   logic          filt_en;
   logic          filt_sel;
   logic [W-1:0]  filt_in;
   logic [W-1:0]  filt_out;
   logic [CW-1:0] frames_done;
   logic [CW-1:0] drop_count;
   logic          busy;

   audio_filter_sequencer #(.WIDTH(W), .TIMEOUT(TMO), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset),
      .read_ready(read_ready), .readdata_left(readdata_left), .readdata_right(readdata_right),
      .read(read), .write_ready(write_ready),
      .writedata_left(writedata_left), .writedata_right(writedata_right), .write(write),
      .bypass(bypass), .filt_en(filt_en), .filt_sel(filt_sel), .filt_in(filt_in),
      .filt_out(filt_out), .frames_done(frames_done), .drop_count(drop_count), .busy(busy)
   );

   // Stand-in filter engine: input/8 (arithmetic shift, rounds toward -inf).
   assign filt_out = $signed(filt_in) >>> 3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] div8(input logic [W-1:0] x);
      int v;
      int q;
      v = $signed(x);
      if (v < 0) q = -((-v + 7) / 8);
      else       q = v / 8;
      return W'(q);
   endfunction

   typedef struct {
      logic [W-1:0] l;
      logic [W-1:0] r;
   } frame_t;

   frame_t exp_q[$];

   // Model state: at most one frame in flight, accepted at cycle ta.
   bit           pend = 0;
   bit           pbyp = 0;
   int           ta = 0;
   int           cyc = 0;
   logic [W-1:0] pl, pr;
   int           m_frames = 0;
   int           m_drops = 0;

   always @(negedge clk) begin
      int     k;
      bit     e_read, e_fe, e_sel, e_busy, e_wr;
      logic [W-1:0] e_fin;
      frame_t f;
      cyc++;
      chk("frames_done", 32'(frames_done), 32'(m_frames));
      chk("drop_count", 32'(drop_count), 32'(m_drops));
      if (reset) begin
         chk("rst_read", 32'(read), 0);
         chk("rst_write", 32'(write), 0);
         chk("rst_filt_en", 32'(filt_en), 0);
         chk("rst_busy", 32'(busy), 0);
         pend = 0;
         exp_q.delete();
         m_frames = 0;
         m_drops = 0;
      end else begin
         k      = cyc - ta;
         e_read = !pend && read_ready;
         e_fe   = pend && !pbyp && (k == 1 || k == 2);
         e_sel  = pend && (k == 2);
         e_fin  = (pend && k == 1) ? pl : (pend && k == 2) ? pr : '0;
         e_busy = pend && (k >= 1);
         e_wr   = pend && (k >= 3) && (k <= 2 + TMO) && write_ready;
         chk("read", 32'(read), 32'(e_read));
         chk("filt_en", 32'(filt_en), 32'(e_fe));
         chk("filt_sel", 32'(filt_sel), 32'(e_sel));
         chk("filt_in", 32'(filt_in), 32'(e_fin));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("write", 32'(write), 32'(e_wr));
         if (e_wr && exp_q.size() > 0) begin
            f = exp_q.pop_front();
            chk("writedata_left", 32'(writedata_left), 32'(f.l));
            chk("writedata_right", 32'(writedata_right), 32'(f.r));
            $display("frame written: L=%06h R=%06h byp=%0d cycle=%0d", writedata_left, writedata_right, pbyp, cyc);
            m_frames = (m_frames + 1) % (1 << CW);
            pend = 0;
         end else if (pend && k == 2 + TMO) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            $display("frame dropped: cycle=%0d", cyc);
            if (m_drops < (1 << CW) - 1) m_drops++;
            pend = 0;
         end
         if (e_read) begin
            pend = 1;
            ta   = cyc;
            pbyp = bypass;
            pl   = readdata_left;
            pr   = readdata_right;
            f.l  = bypass ? readdata_left : div8(readdata_left);
            f.r  = bypass ? readdata_right : div8(readdata_right);
            exp_q.push_back(f);
         end
      end
   end

   task automatic drive(input bit rr, input logic [W-1:0] l, input logic [W-1:0] r,
                        input bit byp, input bit wr, input bit rst);
      @(posedge clk);
      #1;
      read_ready     = rr;
      readdata_left  = l;
      readdata_right = r;
      bypass         = byp;
      write_ready    = wr;
      reset          = rst;
   endtask

   task automatic idle(input int n, input bit wr);
      for (int i = 0; i < n; i++) drive(0, '0, '0, 0, wr, 0);
   endtask

   initial begin
      bit slow;
      reset = 1; read_ready = 0; readdata_left = '0; readdata_right = '0;
      bypass = 0; write_ready = 0;
      repeat (3) drive(0, '0, '0, 0, 0, 1);
      drive(0, '0, '0, 0, 1, 0);
      chk("reset_wdl", 32'(writedata_left), 0);
      chk("reset_wdr", 32'(writedata_right), 0);
      chk("reset_frames", 32'(frames_done), 0);
      chk("reset_drops", 32'(drop_count), 0);
      chk("reset_busy", 32'(busy), 0);

      // Filtered frame, then bypassed full-scale frame.
      drive(1, W'(100), W'(-200), 0, 1, 0);
      idle(5, 1);
      drive(1, 24'h7FFFFF, 24'h800000, 1, 1, 0);
      idle(5, 1);

      // Timeout drop, then a normal frame is accepted.
      drive(1, W'(7), W'(-9), 0, 0, 0);
      idle(14, 0);
      drive(1, W'(800), W'(-8), 0, 1, 0);
      idle(5, 1);

      // write_ready rises on the last WAIT_WR cycle: write wins.
      drive(1, W'(64), W'(-64), 0, 0, 0);
      idle(9, 0);
      drive(0, '0, '0, 0, 1, 0);
      idle(4, 1);

      // Continuous read_ready: one frame every 4 cycles.
      for (int i = 0; i < 40; i++) drive(1, W'($urandom), W'($urandom), 0, 1, 0);
      idle(3, 1);

      // Reset while the frame is in FILT_R.
      drive(1, W'(5), W'(6), 0, 1, 0);
      drive(0, '0, '0, 0, 1, 0);
      drive(0, '0, '0, 0, 1, 1);
      drive(0, '0, '0, 0, 1, 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_write", 32'(write), 0);
      chk("midrst_wdr", 32'(writedata_right), 0);
      chk("midrst_frames", 32'(frames_done), 0);
      chk("midrst_drops", 32'(drop_count), 0);
      idle(3, 1);

      // Randomized traffic with slow-codec phases to exercise timeouts.
      slow = 0;
      for (int i = 0; i < 3000; i++) begin
         if (i % 150 == 0) slow = ~slow;
         drive(($urandom % 3) != 0, W'($urandom), W'($urandom), ($urandom % 4) == 0,
               slow ? (($urandom % 20) == 0) : (($urandom % 10) != 0),
               ($urandom % 600) == 0);
      end
      idle(TMO + 4, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
